rvfi_commit_serializer: RTL and testbench
=========================================

// Module: rvfi_commit_serializer
// PURPOSE
//  Sits between the core's multi-port RVFI commit interface and the single-stream trace/checker consumer.
//  Each cycle it captures every commit port entry with valid or trap set, queues it in program order
//  (lower port index = older), and emits one entry per cycle on a valid/ready handshake.
//  Ordering is preserved for downstream consumers; overflow is detected and counted.
// PARAMETERS
//  NR_COMMIT_PORTS  2   number of RVFI commit ports sampled per cycle
//  DEPTH            8   FIFO entries; power of two, >= NR_COMMIT_PORTS
//  CNT_W            32  width of drop counter
// PORTS
//  clk_i       in   1                                  clock, all state on posedge
//  rst_ni      in   1                                  reset, synchronous active-low
//  rvfi_i      in   rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0]  commit port entries
//  flush_i     in   1                                  sync FIFO clear (counters kept)
//  valid_o     out  1                                  rvfi_o holds an entry
//  ready_i     in   1                                  consumer accepts rvfi_o this cycle
//  rvfi_o      out  rvfi_pkg::rvfi_instr_t             head-of-queue entry
//  count_o     out  $clog2(DEPTH)+1                    current occupancy
//  overflow_o  out  1                                  sticky: at least one entry dropped
//  drop_cnt_o  out  CNT_W                              dropped entries, saturating
//  order_o     out  64                                 retire sequence number of rvfi_o (macro only)
// BEHAVIOUR
//  - Reset (rst_ni=0 at posedge): rd/wr ptrs=0, count_o=0, valid_o=0, overflow_o=0, drop_cnt_o=0,
//    order_o=0, seq counter=0; rvfi_o undefined-but-stable while valid_o=0. Reset mid-burst drops queue, no count.
//  - Capture: port i qualifies iff rvfi_i[i].valid | rvfi_i[i].trap. Qualifying ports compacted in
//    ascending index order, written at consecutive wr_ptr slots in one edge.
//  - Free space = DEPTH - count at start of cycle; a same-cycle pop does NOT free space for pushes.
//  - If qualifying > free: first 'free' (in port order) accepted, rest dropped; drop_cnt_o += dropped
//    (saturate at 2^CNT_W-1); overflow_o set, sticky until reset.
//  - Output: valid_o = (count != 0); rvfi_o = storage[rd_ptr]. Push at edge N -> visible at valid_o
//    after edge N (1-cycle latency). Pop iff valid_o & ready_i; rvfi_o stable while valid_o & ~ready_i.
//  - count_next = count + pushed - popped; ptrs wrap modulo DEPTH (mask arithmetic).
//  - flush_i: queue emptied at next edge; flush wins over same-cycle push and pop; drop_cnt_o,
//    overflow_o, seq counter unchanged; pushes suppressed in flush cycle are not counted as drops.
//  - No FSM beyond FIFO; full (count=DEPTH) with pop: pop proceeds, all pushes in that cycle dropped.
// CONFIGURATION
//  RVFI_SERIALIZER_SEQ_EN defined: 64-bit seq counter stored alongside each accepted entry
//    (incremented per accepted entry, port order, wraps at 2^64); order_o = seq of head entry.
//    Dropped entries consume no sequence number; flush does not reset it.
//  Not defined: no seq storage; order_o tied to 64'h0.
// TESTING
//  1 Reset, both ports valid with insn 0x00000013 / 0x00100093, ready_i=1 -> next cycle valid_o,
//    port0 entry out first, port1 entry following cycle; count_o 2->1->0.
//  2 ready_i=0, 5 cycles x 2 valid ports, DEPTH=8 -> count_o=8, drop_cnt_o=2, overflow_o=1,
//    head = first port0 entry.
//  3 count=7, ready_i=1, both ports valid -> port0 accepted, port1 dropped, count_o stays 7.
//  4 Port0 idle, port1 trap=1 only -> one entry queued with trap=1, valid=0.
//  5 Queue of 4, flush_i=1 with both ports valid -> count_o=0, valid_o=0, drop_cnt_o unchanged.
//  6 SEQ_EN: 3 accepted, 1 dropped, 2 more accepted -> order_o sequence 0,1,2,3,4; without macro always 0.

Source files
------------

// File: rtl/rvfi_pkg.sv
// RVFI commit-port entry type shared by the core, the serializer and trace consumers.
`timescale 1ns/1ps
package rvfi_pkg;

  typedef struct packed {
    logic        valid;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } rvfi_instr_t;

endpackage

// File: rtl/rvfi_commit_serializer.sv
// Serializes multi-port RVFI commits into one in-order valid/ready stream with overflow counting.
// Optional feature macro: RVFI_SERIALIZER_SEQ_EN (per-entry 64-bit retire sequence number on order_o).
`timescale 1ns/1ps
module rvfi_commit_serializer
  import rvfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]    rvfi_i,
  input  logic                                 flush_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output rvfi_instr_t                          rvfi_o,
  output logic [$clog2(DEPTH):0]               count_o,
  output logic                                 overflow_o,
  output logic [CNT_W-1:0]                     drop_cnt_o,
  output logic [63:0]                          order_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  rvfi_instr_t        r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  logic [CNT_W-1:0]   r_drop_cnt;

  logic [NR_COMMIT_PORTS-1:0] w_qual;
  logic [NR_COMMIT_PORTS-1:0] w_acc;
  logic [CW-1:0]              w_slot [NR_COMMIT_PORTS];
  logic [PTR_W-1:0]           w_widx [NR_COMMIT_PORTS];
  logic [CW-1:0]              w_nq;
  logic [CW-1:0]              w_free;
  logic [CW-1:0]              w_npush;
  logic [CW-1:0]              w_ndrop;
  logic                       w_valid;
  logic                       w_pop;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & ready_i;
  // Space is judged on start-of-cycle occupancy; a same-cycle pop never makes room.
  assign w_free  = CW'(DEPTH) - r_count;

  // Capture stage: compact qualifying ports in ascending index order
  always_comb begin
    w_nq = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      w_qual[i] = rvfi_i[i].valid | rvfi_i[i].trap;
      w_slot[i] = w_nq;
      w_acc[i]  = w_qual[i] && (w_slot[i] < w_free);
      w_widx[i] = r_wr_ptr + w_slot[i][PTR_W-1:0];
      if (w_qual[i]) w_nq = w_nq + ONE;
    end
  end

  assign w_npush = (w_nq < w_free) ? w_nq : w_free;
  assign w_ndrop = w_nq - w_npush;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_npush[PTR_W-1:0];
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_count  <= r_count + w_npush - CW'(w_pop);
      if (w_ndrop != '0) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= sat_add(r_drop_cnt, CNT_W'(w_ndrop));
      end
    end
  end

  // Storage stage: entry data is not reset; occupancy alone decides what is live
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (w_acc[i] && !flush_i) r_mem[w_widx[i]] <= rvfi_i[i];
    end
  end

`ifdef RVFI_SERIALIZER_SEQ_EN
  logic [63:0] r_seq;
  logic [63:0] r_seq_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_seq <= '0;
    end else if (!flush_i) begin
      r_seq <= r_seq + 64'(w_npush);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (w_acc[i] && !flush_i) r_seq_mem[w_widx[i]] <= r_seq + 64'(w_slot[i]);
    end
  end

  assign order_o = w_valid ? r_seq_mem[r_rd_ptr] : 64'h0;
`else
  assign order_o = 64'h0;
`endif

  // Output stage: head of queue
  assign valid_o    = w_valid;
  assign rvfi_o     = r_mem[r_rd_ptr];
  assign count_o    = r_count;
  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Directed bench for rvfi_commit_serializer with hand-computed expectations.
`timescale 1ns/1ps
module tb_rvfi_commit_serializer;
  import rvfi_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  rvfi_instr_t [1:0]     rvfi_i;
  logic                  flush_i;
  logic                  valid_o;
  logic                  ready_i;
  rvfi_instr_t           rvfi_o;
  logic [3:0]            count_o;
  logic                  overflow_o;
  logic [31:0]           drop_cnt_o;
  logic [63:0]           order_o;

  int n_chk  = 0;
  int n_fail = 0;

  rvfi_commit_serializer #(.NR_COMMIT_PORTS(2), .DEPTH(8), .CNT_W(32)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rvfi_i     (rvfi_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .rvfi_o     (rvfi_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o),
    .order_o    (order_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic rvfi_instr_t mk(input logic v, input logic t, input logic [31:0] insn);
    rvfi_instr_t e;
    e          = '0;
    e.valid    = v;
    e.trap     = t;
    e.insn     = insn;
    e.pc_rdata = insn ^ 32'h8000_0000;
    return e;
  endfunction

  function automatic logic [63:0] exp_ord(input logic [63:0] n);
`ifdef RVFI_SERIALIZER_SEQ_EN
    return n;
`else
    return 64'h0 & n;
`endif
  endfunction

  task automatic drive(input logic v0, input logic t0, input logic [31:0] i0,
                       input logic v1, input logic t1, input logic [31:0] i1);
    rvfi_i[0] = mk(v0, t0, i0);
    rvfi_i[1] = mk(v1, t1, i1);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 64'(count_o), 64'd0);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_ovf"},   64'(overflow_o), 64'd0);
    chk({tag, "_drop"},  64'(drop_cnt_o), 64'd0);
    chk({tag, "_order"}, order_o, 64'd0);
  endtask

  initial begin
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    idle();
    tick();
    tick();
    chk_reset_state("reset");
    rst_ni = 1'b1;

    // Two ports in one cycle, drained in port order
    drive(1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0, 32'h0010_0093);
    ready_i = 1'b1;
    tick();
    idle();
    chk("t1_valid", 64'(valid_o), 64'd1);
    chk("t1_count2", 64'(count_o), 64'd2);
    chk("t1_head0", 64'(rvfi_o.insn), 64'h0000_0013);
    chk("t1_pc0", 64'(rvfi_o.pc_rdata), 64'h8000_0013);
    chk("t1_ord0", order_o, exp_ord(64'd0));
    tick();
    chk("t1_count1", 64'(count_o), 64'd1);
    chk("t1_head1", 64'(rvfi_o.insn), 64'h0010_0093);
    chk("t1_ord1", order_o, exp_ord(64'd1));
    tick();
    chk("t1_count0", 64'(count_o), 64'd0);
    chk("t1_empty", 64'(valid_o), 64'd0);

    // Backpressure fills the queue and drops the last pair
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 32'h100 + 32'(2*k), 1'b1, 1'b0, 32'h101 + 32'(2*k));
      tick();
    end
    idle();
    chk("t2_count", 64'(count_o), 64'd8);
    chk("t2_drop", 64'(drop_cnt_o), 64'd2);
    chk("t2_ovf", 64'(overflow_o), 64'd1);
    chk("t2_head", 64'(rvfi_o.insn), 64'h100);
    chk("t2_ord", order_o, exp_ord(64'd2));
    tick();
    chk("t2_hold", 64'(rvfi_o.insn), 64'h100);

    // Count 7: a same-cycle pop does not free space for port1
    ready_i = 1'b1;
    tick();
    chk("t3_count7", 64'(count_o), 64'd7);
    chk("t3_head", 64'(rvfi_o.insn), 64'h101);
    chk("t3_ord", order_o, exp_ord(64'd3));
    drive(1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h201);
    tick();
    idle();
    chk("t3_count", 64'(count_o), 64'd7);
    chk("t3_drop", 64'(drop_cnt_o), 64'd3);
    chk("t3_head2", 64'(rvfi_o.insn), 64'h102);
    chk("t3_ord2", order_o, exp_ord(64'd4));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t3_flush", 64'(count_o), 64'd0);
    chk("t3_ovf_kept", 64'(overflow_o), 64'd1);

    // Trap-only port1 qualifies
    ready_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    tick();
    idle();
    chk("t4_count", 64'(count_o), 64'd1);
    chk("t4_trap", 64'(rvfi_o.trap), 64'd1);
    chk("t4_vbit", 64'(rvfi_o.valid), 64'd0);
    chk("t4_insn", 64'(rvfi_o.insn), 64'h300);
    chk("t4_ord", order_o, exp_ord(64'd11));

    // Flush a queue of 4 against a same-cycle push and pop
    drive(1'b1, 1'b0, 32'h301, 1'b1, 1'b0, 32'h302);
    tick();
    drive(1'b1, 1'b0, 32'h303, 1'b0, 1'b0, 32'h0);
    tick();
    chk("t5_count4", 64'(count_o), 64'd4);
    drive(1'b1, 1'b0, 32'h3F0, 1'b1, 1'b0, 32'h3F1);
    ready_i = 1'b1;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    ready_i = 1'b0;
    idle();
    chk("t5_count", 64'(count_o), 64'd0);
    chk("t5_valid", 64'(valid_o), 64'd0);
    chk("t5_drop", 64'(drop_cnt_o), 64'd3);
    drive(1'b1, 1'b0, 32'h310, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    chk("t5_seq_kept", order_o, exp_ord(64'd15));

    // Reset with a live queue clears everything
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk_reset_state("rst2");

    // Sequence numbers skip nothing across drops, including full-with-pop
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, (c < 4) ? 32'h400 + 32'(2*c) : 32'h4F0,
            1'b1, 1'b0, (c < 4) ? 32'h401 + 32'(2*c) : 32'h4F1);
      tick();
    end
    chk("t6_full", 64'(count_o), 64'd8);
    chk("t6_drop2", 64'(drop_cnt_o), 64'd2);
    chk("t6_ord0", order_o, exp_ord(64'd0));
    ready_i = 1'b1;
    drive(1'b1, 1'b0, 32'h4F2, 1'b1, 1'b0, 32'h4F3);
    tick();
    idle();
    chk("t6_fullpop_cnt", 64'(count_o), 64'd7);
    chk("t6_fullpop_drop", 64'(drop_cnt_o), 64'd4);
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("t6_insn%0d", k), 64'(rvfi_o.insn), 64'h400 + 64'(k));
      chk($sformatf("t6_ord%0d", k), order_o, exp_ord(64'(k)));
      tick();
    end
    chk("t6_drained", 64'(valid_o), 64'd0);
    ready_i = 1'b0;
    drive(1'b1, 1'b0, 32'h500, 1'b1, 1'b0, 32'h501);
    tick();
    idle();
    chk("t6_ord8", order_o, exp_ord(64'd8));
    ready_i = 1'b1;
    tick();
    chk("t6_insn9", 64'(rvfi_o.insn), 64'h501);
    chk("t6_ord9", order_o, exp_ord(64'd9));
    tick();
    chk("t6_end_count", 64'(count_o), 64'd0);
    chk("t6_end_order", order_o, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
